// File: rtl/video_timing_pkg.sv
// Shared video timing constants, region type and helpers for the raster
// generator and its axis counters.
package video_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int MAX_TOTAL = 2048;

    localparam logic SYNC_POS = 1'b1;
    localparam logic SYNC_NEG = 1'b0;

    // 800x600@60 on the 39.75 MHz PLL dot clock
    localparam int   SVGA_H_ACTIVE = 800;
    localparam int   SVGA_H_FP     = 40;
    localparam int   SVGA_H_SYNC   = 128;
    localparam int   SVGA_H_BP     = 88;
    localparam int   SVGA_V_ACTIVE = 600;
    localparam int   SVGA_V_FP     = 1;
    localparam int   SVGA_V_SYNC   = 4;
    localparam int   SVGA_V_BP     = 23;
    localparam logic SVGA_HS_POL   = SYNC_POS;
    localparam logic SVGA_VS_POL   = SYNC_POS;

    // 640x480@60 on a 25.175 MHz dot clock
    localparam int   VGA_H_ACTIVE  = 640;
    localparam int   VGA_H_FP      = 16;
    localparam int   VGA_H_SYNC    = 96;
    localparam int   VGA_H_BP      = 48;
    localparam int   VGA_V_ACTIVE  = 480;
    localparam int   VGA_V_FP      = 10;
    localparam int   VGA_V_SYNC    = 2;
    localparam int   VGA_V_BP      = 33;
    localparam logic VGA_HS_POL    = SYNC_NEG;
    localparam logic VGA_VS_POL    = SYNC_NEG;

    typedef enum logic [1:0] {
        REGION_ACTIVE,
        REGION_FRONT,
        REGION_SYNC,
        REGION_BACK
    } axis_region_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_raster_gen_if.sv
// Raster output bundle: timing strobes, syncs, coordinates and the line
// interrupt request, with the generator as master and the consumer as slave.
interface vga_raster_gen_if;

    logic [video_timing_pkg::COORD_W-1:0] irq_line;
    logic                                 vid_new_frame;
    logic                                 vid_new_line;
    logic                                 vid_active;
    logic                                 vga_hsync;
    logic                                 vga_vsync;
    logic [video_timing_pkg::COORD_W-1:0] pel_x;
    logic [video_timing_pkg::COORD_W-1:0] pel_y;
    logic                                 line_irq;
    logic [15:0]                          frame_cnt;

    modport master (
        input  irq_line,
        output vid_new_frame,
        output vid_new_line,
        output vid_active,
        output vga_hsync,
        output vga_vsync,
        output pel_x,
        output pel_y,
        output line_irq,
        output frame_cnt
    );

    modport slave (
        output irq_line,
        input  vid_new_frame,
        input  vid_new_line,
        input  vid_active,
        input  vga_hsync,
        input  vga_vsync,
        input  pel_x,
        input  pel_y,
        input  line_irq,
        input  frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter plus decode of which region
// (active / front porch / sync / back porch) the current count lies in.
module vga_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = SVGA_H_ACTIVE,
    parameter int FP     = SVGA_H_FP,
    parameter int SYNC   = SVGA_H_SYNC,
    parameter int BP     = SVGA_H_BP,
    parameter int W      = COORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last,
    output axis_region_t region
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST_COUNT  = W'(TOTAL - 1);
    localparam logic [W:0]   FRONT_START = (W+1)'(ACTIVE);
    localparam logic [W:0]   SYNC_START  = (W+1)'(ACTIVE + FP);
    localparam logic [W:0]   BACK_START  = (W+1)'(ACTIVE + FP + SYNC);

    // Region bounds may equal TOTAL when a porch is empty, so compare one bit wider.
    logic [W:0] count_ext;

    assign count_ext = {1'b0, count};
    assign last      = (count == LAST_COUNT);

    // Reset parks the counter on its final count so the first enabled edge wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST_COUNT;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

    always_comb begin
        region = REGION_BACK;
        if (count_ext < FRONT_START) begin
            region = REGION_ACTIVE;
        end else if (count_ext < SYNC_START) begin
            region = REGION_FRONT;
        end else if (count_ext < BACK_START) begin
            region = REGION_SYNC;
        end
    end

endmodule

// File: rtl/vga_raster_gen.sv
// Video timing and raster stage: registered syncs, strobes, pixel coordinates,
// per-frame programmable line interrupt and completed-frame counter.
module vga_raster_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = SVGA_H_ACTIVE,
    parameter int   H_FP     = SVGA_H_FP,
    parameter int   H_SYNC   = SVGA_H_SYNC,
    parameter int   H_BP     = SVGA_H_BP,
    parameter int   V_ACTIVE = SVGA_V_ACTIVE,
    parameter int   V_FP     = SVGA_V_FP,
    parameter int   V_SYNC   = SVGA_V_SYNC,
    parameter int   V_BP     = SVGA_V_BP,
    parameter logic HS_POL   = SVGA_HS_POL,
    parameter logic VS_POL   = SVGA_VS_POL
) (
    input  logic              clk_dot,
    input  logic              reset_n,
    vga_raster_gen_if.master  vid
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $fatal(1, "vga_raster_gen: H_TOTAL (%0d) and V_TOTAL (%0d) must not exceed %0d",
               H_TOTAL, V_TOTAL, MAX_TOTAL);
    end

    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               h_last;
    logic               v_last;
    axis_region_t       h_region;
    axis_region_t       v_region;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (COORD_W)
    ) u_h_axis (
        .clk    (clk_dot),
        .rst_n  (reset_n),
        .en     (1'b1),
        .count  (h_count),
        .last   (h_last),
        .region (h_region)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (COORD_W)
    ) u_v_axis (
        .clk    (clk_dot),
        .rst_n  (reset_n),
        .en     (h_last),
        .count  (v_count),
        .last   (v_last),
        .region (v_region)
    );

    logic               frame_end;
    logic               active_next;
    logic               irq_next;
    logic [COORD_W-1:0] shadow_q;
    logic               first_frame_done_q;

    logic               new_frame_q;
    logic               new_line_q;
    logic               active_q;
    logic               hsync_q;
    logic               vsync_q;
    logic [COORD_W-1:0] pel_x_q;
    logic [COORD_W-1:0] pel_y_q;
    logic               line_irq_q;
    logic [15:0]        frame_cnt_q;

    // At the frame boundary the freshly sampled irq_line is compared directly so
    // a request for line 0 lands on the same strobe that latches it.
    always_comb begin
        frame_end   = h_last && v_last;
        active_next = (h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE);
        irq_next    = 1'b0;
        if (frame_end) begin
            irq_next = (vid.irq_line == '0);
        end else if (h_last) begin
            irq_next = ((v_count + COORD_W'(1)) == shadow_q);
        end
    end

    // Every output is a registered decode of the counter state one clock earlier.
    always_ff @(posedge clk_dot or negedge reset_n) begin
        if (!reset_n) begin
            new_frame_q <= 1'b0;
            new_line_q  <= 1'b0;
            active_q    <= 1'b0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            pel_x_q     <= '0;
            pel_y_q     <= '0;
            line_irq_q  <= 1'b0;
            shadow_q    <= '1;
        end else begin
            new_frame_q <= frame_end;
            new_line_q  <= h_last;
            active_q    <= active_next;
            hsync_q     <= sync_level(h_region == REGION_SYNC, HS_POL);
            vsync_q     <= sync_level(v_region == REGION_SYNC, VS_POL);
            pel_x_q     <= active_next ? h_count : '0;
            pel_y_q     <= v_count;
            line_irq_q  <= irq_next;
            if (frame_end) begin
                shadow_q <= vid.irq_line;
            end
        end
    end

    // The frame start right after reset is not a completed frame, so it only arms the count.
    always_ff @(posedge clk_dot or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q        <= '0;
            first_frame_done_q <= 1'b0;
        end else if (new_frame_q) begin
            first_frame_done_q <= 1'b1;
            if (first_frame_done_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign vid.vid_new_frame = new_frame_q;
    assign vid.vid_new_line  = new_line_q;
    assign vid.vid_active    = active_q;
    assign vid.vga_hsync     = hsync_q;
    assign vid.vga_vsync     = vsync_q;
    assign vid.pel_x         = pel_x_q;
    assign vid.pel_y         = pel_y_q;
    assign vid.line_irq      = line_irq_q;
    assign vid.frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_vga_raster_gen.sv
// Self-checking bench: small-timing DUTs (both sync polarities) and a default
// 800x600 DUT compared each clock against a position-based reference model.
module tb_vga_raster_gen;
    import video_timing_pkg::*;

    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT = 15, S_VT = 8, S_FT = S_HT * S_VT;
    localparam int D_HT = 1056, D_VT = 628, D_FT = D_HT * D_VT;

    logic               clk_dot;
    logic               reset_n;
    logic [COORD_W-1:0] irq_line;

    int checkCount = 0;
    int errorCount = 0;

    int k;
    int shadowS, shadowD;
    int startsS, startsD;
    bit randomIrq;

    vga_raster_gen_if vifS ();
    vga_raster_gen_if vifN ();
    vga_raster_gen_if vifD ();

    assign vifS.irq_line = irq_line;
    assign vifN.irq_line = irq_line;
    assign vifD.irq_line = irq_line;

    vga_raster_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dutS (
        .clk_dot (clk_dot),
        .reset_n (reset_n),
        .vid     (vifS)
    );

    vga_raster_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dutN (
        .clk_dot (clk_dot),
        .reset_n (reset_n),
        .vid     (vifN)
    );

    vga_raster_gen dutD (
        .clk_dot (clk_dot),
        .reset_n (reset_n),
        .vid     (vifD)
    );

    initial clk_dot = 1'b0;
    always #5 clk_dot = ~clk_dot;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Expected outputs derived from the raster position (pos = linear pixel index in the frame).
    task automatic checkDut(input string name, input int ht, input int vt,
                            input int ha, input int hf, input int hs,
                            input int va, input int vf, input int vs,
                            input bit hpol, input bit vpol,
                            input int pos, input int shadow, input int fcnt,
                            input int oNf, input int oNl, input int oAct,
                            input int oHs, input int oVs, input int oPx,
                            input int oPy, input int oIrq, input int oFc);
        int x, y, act, nl, nf, expHs, expVs, expIrq;
        x      = pos % ht;
        y      = pos / ht;
        act    = (x < ha && y < va) ? 1 : 0;
        nl     = (x == ht - 1) ? 1 : 0;
        nf     = (nl == 1 && y == vt - 1) ? 1 : 0;
        expHs  = (x >= ha + hf && x < ha + hf + hs) ? int'(hpol) : int'(!hpol);
        expVs  = (y >= va + vf && y < va + vf + vs) ? int'(vpol) : int'(!vpol);
        expIrq = (nl == 1 && ((y + 1) % vt) == shadow) ? 1 : 0;
        checkOutput({name, ".vid_new_frame"}, oNf, nf);
        checkOutput({name, ".vid_new_line"}, oNl, nl);
        checkOutput({name, ".vid_active"}, oAct, act);
        checkOutput({name, ".vga_hsync"}, oHs, expHs);
        checkOutput({name, ".vga_vsync"}, oVs, expVs);
        checkOutput({name, ".pel_x"}, oPx, (act == 1) ? x : 0);
        checkOutput({name, ".pel_y"}, oPy, y);
        checkOutput({name, ".line_irq"}, oIrq, expIrq);
        checkOutput({name, ".frame_cnt"}, oFc, fcnt);
    endtask

    task automatic checkReset(input string name, input bit hpol, input bit vpol,
                              input int oNf, input int oNl, input int oAct,
                              input int oHs, input int oVs, input int oPx,
                              input int oPy, input int oIrq, input int oFc);
        checkOutput({name, ".rst_new_frame"}, oNf, 0);
        checkOutput({name, ".rst_new_line"}, oNl, 0);
        checkOutput({name, ".rst_active"}, oAct, 0);
        checkOutput({name, ".rst_hsync"}, oHs, int'(!hpol));
        checkOutput({name, ".rst_vsync"}, oVs, int'(!vpol));
        checkOutput({name, ".rst_pel_x"}, oPx, 0);
        checkOutput({name, ".rst_pel_y"}, oPy, 0);
        checkOutput({name, ".rst_line_irq"}, oIrq, 0);
        checkOutput({name, ".rst_frame_cnt"}, oFc, 0);
    endtask

    task automatic checkResetAll();
        checkReset("small", 1'b1, 1'b1, vifS.vid_new_frame, vifS.vid_new_line, vifS.vid_active,
                   vifS.vga_hsync, vifS.vga_vsync, vifS.pel_x, vifS.pel_y, vifS.line_irq,
                   vifS.frame_cnt);
        checkReset("neg", 1'b0, 1'b0, vifN.vid_new_frame, vifN.vid_new_line, vifN.vid_active,
                   vifN.vga_hsync, vifN.vga_vsync, vifN.pel_x, vifN.pel_y, vifN.line_irq,
                   vifN.frame_cnt);
        checkReset("svga", 1'b1, 1'b1, vifD.vid_new_frame, vifD.vid_new_line, vifD.vid_active,
                   vifD.vga_hsync, vifD.vga_vsync, vifD.pel_x, vifD.pel_y, vifD.line_irq,
                   vifD.frame_cnt);
    endtask

    // Asserts reset between edges, checks it took effect before any edge, holds, then releases.
    task automatic applyReset(input int cycles);
        reset_n = 1'b0;
        #1;
        checkResetAll();
        repeat (cycles) begin
            @(posedge clk_dot);
            #1;
            checkResetAll();
        end
        reset_n = 1'b1;
        k       = 0;
        startsS = 0;
        startsD = 0;
        shadowS = 'h7FF;
        shadowD = 'h7FF;
    endtask

    // One clock: the first edge after release shows the last position of the previous frame.
    task automatic runCycle();
        int posS, posD, fcS, fcD;
        @(posedge clk_dot);
        #1;
        k++;
        posS = (k + S_FT - 2) % S_FT;
        posD = (k + D_FT - 2) % D_FT;
        if (posS == S_FT - 1) shadowS = int'(irq_line);
        if (posD == D_FT - 1) shadowD = int'(irq_line);
        fcS = (startsS > 0) ? (startsS - 1) % 65536 : 0;
        fcD = (startsD > 0) ? (startsD - 1) % 65536 : 0;
        checkDut("small", S_HT, S_VT, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b1, 1'b1,
                 posS, shadowS, fcS,
                 vifS.vid_new_frame, vifS.vid_new_line, vifS.vid_active, vifS.vga_hsync,
                 vifS.vga_vsync, vifS.pel_x, vifS.pel_y, vifS.line_irq, vifS.frame_cnt);
        checkDut("neg", S_HT, S_VT, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b0, 1'b0,
                 posS, shadowS, fcS,
                 vifN.vid_new_frame, vifN.vid_new_line, vifN.vid_active, vifN.vga_hsync,
                 vifN.vga_vsync, vifN.pel_x, vifN.pel_y, vifN.line_irq, vifN.frame_cnt);
        checkDut("svga", D_HT, D_VT, SVGA_H_ACTIVE, SVGA_H_FP, SVGA_H_SYNC,
                 SVGA_V_ACTIVE, SVGA_V_FP, SVGA_V_SYNC, 1'b1, 1'b1,
                 posD, shadowD, fcD,
                 vifD.vid_new_frame, vifD.vid_new_line, vifD.vid_active, vifD.vga_hsync,
                 vifD.vga_vsync, vifD.pel_x, vifD.pel_y, vifD.line_irq, vifD.frame_cnt);
        if (posS == S_FT - 1) startsS++;
        if (posD == D_FT - 1) startsD++;
    endtask

    task automatic applyStimulus();
        if (randomIrq) begin
            if ($urandom_range(0, 59) == 0) irq_line = COORD_W'($urandom_range(0, 10));
        end else if (k == 40) begin
            irq_line = 11'd2;
        end else if (k == 200) begin
            irq_line = 11'd9;
        end
    endtask

    initial begin
        int irqCount0, irqCount1, irqCount2, irqK0, irqK1;
        int vsCount, vsFirst, vsCountN;
        int actCountD, hsCountD, hsFirstD, nlSecondD;
        int frameStarts[$];

        irqCount0 = 0; irqCount1 = 0; irqCount2 = 0; irqK0 = 0; irqK1 = 0;
        vsCount = 0; vsFirst = 0; vsCountN = 0;
        actCountD = 0; hsCountD = 0; hsFirstD = 0; nlSecondD = 0;
        randomIrq = 1'b0;
        reset_n   = 1'b1;
        irq_line  = 11'd6;
        k         = 0;
        #2;
        applyReset(3);

        for (int n = 0; n < 2300; n++) begin
            runCycle();
            if (vifS.line_irq) begin
                if (k <= 120) begin
                    irqCount0++;
                    irqK0 = k;
                end else if (k <= 240) begin
                    irqCount1++;
                    irqK1 = k;
                end else if (k <= 360) begin
                    irqCount2++;
                end
            end
            if (vifS.vid_new_frame) frameStarts.push_back(k);
            if (k >= 2 && k <= 121) begin
                if (vifS.vga_vsync) begin
                    vsCount++;
                    if (vsFirst == 0) vsFirst = k;
                end
                if (!vifN.vga_vsync) vsCountN++;
            end
            if (k == 2)   checkOutput("frame_cnt_first_start", vifS.frame_cnt, 0);
            if (k == 122) checkOutput("frame_cnt_second_start", vifS.frame_cnt, 1);
            if (k == 362) checkOutput("frame_cnt_fourth_start", vifS.frame_cnt, 3);
            if (k >= 2 && k <= 1057) begin
                if (vifD.vid_active) actCountD++;
                if (vifD.vga_hsync) begin
                    hsCountD++;
                    if (hsFirstD == 0) hsFirstD = k;
                end
            end
            if (k > 1 && vifD.vid_new_line && nlSecondD == 0) nlSecondD = k;
            applyStimulus();
        end

        checkOutput("irq_count_frame0", irqCount0, 1);
        checkOutput("irq_cycle_frame0", irqK0, 91);
        checkOutput("irq_count_frame1", irqCount1, 1);
        checkOutput("irq_cycle_frame1", irqK1, 151);
        checkOutput("irq_count_frame2", irqCount2, 0);
        checkOutput("frame_start_count", frameStarts.size(), 20);
        if (frameStarts.size() >= 3) begin
            checkOutput("frame_period_a", frameStarts[1] - frameStarts[0], 120);
            checkOutput("frame_period_b", frameStarts[2] - frameStarts[1], 120);
        end else begin
            checkOutput("frame_period_a", frameStarts.size(), 3);
        end
        checkOutput("vsync_clocks", vsCount, 30);
        checkOutput("vsync_first_cycle", vsFirst, 77);
        checkOutput("vsync_neg_clocks", vsCountN, 30);
        checkOutput("svga_active_per_line", actCountD, 800);
        checkOutput("svga_hsync_start", hsFirstD, 842);
        checkOutput("svga_hsync_width", hsCountD, 128);
        checkOutput("svga_line_period", nlSecondD, 1057);

        randomIrq = 1'b1;
        applyReset(3);
        runCycle();
        checkOutput("restart_new_frame", vifS.vid_new_frame, 1);
        checkOutput("restart_new_line", vifS.vid_new_line, 1);
        runCycle();
        checkOutput("restart_active", vifS.vid_active, 1);
        checkOutput("restart_pel_x", vifS.pel_x, 0);
        checkOutput("restart_pel_y", vifS.pel_y, 0);

        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(50, 500)) begin
                runCycle();
                applyStimulus();
            end
            applyReset($urandom_range(1, 4));
        end
        repeat (400) begin
            runCycle();
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
